unfifo_drain: RTL

- Read-side companion to the two-clock single-word CDC FIFO ("unfifo").
- Runs entirely in the rclk domain. Pops words from the unfifo read port (rempty/rinc/rdata) and re-presents them as a registered valid/ready stream through a 2-entry skid buffer.
- The rinc it drives never depends combinationally on downstream ready.
- Also provides a delivered-word counter and a downstream-stall watchdog flag.

---
 rtl/unfifo_drain.sv | 101 ++++++++++
 1 files changed

// File: rtl/unfifo_drain.sv
// unfifo_drain: read-side drain for the single-word CDC unfifo.
// Pops into a 2-entry skid buffer and emits a registered valid/ready stream.
module unfifo_drain #(
  parameter int DSIZE       = 16,
  parameter int CNTW        = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic             rclk,
  input  logic             rrst_i,
  input  logic             en_i,
  input  logic             rempty_i,
  input  logic [DSIZE-1:0] rdata_i,
  output logic             rinc_o,
  output logic             m_valid_o,
  output logic [DSIZE-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic [CNTW-1:0]  word_count_o,
  output logic             stall_o
);

  localparam logic [15:0] LIM = 16'(STALL_LIMIT);

  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic [CNTW-1:0]  word_count_q, word_count_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_q, stall_d;

  logic             push;
  logic             pop;
  logic [1:0]       occ_pop;

  // Pop strobe: registered occupancy and unfifo flag only, never m_ready_i.
  always_comb begin
    push = ~rrst_i & en_i & ~rempty_i & (occ_q != 2'd2);
    pop  = (occ_q != 2'd0) & m_ready_i;
  end

  // Skid buffer, delivered-word counter and stall watchdog next state.
  always_comb begin
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    word_count_d = word_count_q;
    stall_cnt_d  = stall_cnt_q;
    occ_pop      = occ_q - {1'b0, pop};

    if (pop && occ_q == 2'd2) begin
      head_d = tail_q;
    end
    if (push) begin
      if (occ_pop == 2'd0) begin
        head_d = rdata_i;
      end else begin
        tail_d = rdata_i;
      end
    end
    occ_d = occ_pop + {1'b0, push};

    if (pop) begin
      word_count_d = word_count_q + CNTW'(1);
    end

    if (pop || occ_q == 2'd0) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != LIM) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    stall_d = (stall_cnt_d == LIM);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge rclk) begin
    if (rrst_i) begin
      occ_q        <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      word_count_q <= '0;
      stall_cnt_q  <= '0;
      stall_q      <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_q      <= stall_d;
    end
  end

  // Output drive.
  always_comb begin
    rinc_o       = push;
    m_valid_o    = (occ_q != 2'd0);
    m_data_o     = head_q;
    word_count_o = word_count_q;
    stall_o      = stall_q;
  end

endmodule
